aclk_multi_alarm_core: RTL and testbench

- Parametrised successor to the single-alarm clock core: BCD real-time clock with NUM_ALARMS independently programmable alarms.
- Each alarm has its own ring/snooze state machine and ring timeout.
- The tick prescaler is parametrised, so the core runs from any integer-multiple reference clock (default 10 Hz).
- Sits between the config/load front end and the display/buzzer drivers.

---
 rtl/aclk_multi_alarm_core.sv | 202 ++++++++++++++++++++
 tb/tb_aclk_multi_alarm_core.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aclk_multi_alarm_core.sv
// BCD real-time clock (HH:MM:SS) with NUM_ALARMS independent alarm channels, each with a ring/snooze FSM.
// Time, alarm_ring, ringing and load_err are registered (one-edge latency); tick decodes the prescaler register.
module aclk_multi_alarm_core #(
  parameter int CLK_DIV        = 10,
  parameter int NUM_ALARMS     = 4,
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  parameter int ASEL_W         = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            H_in1,
  input  logic [3:0]            H_in0,
  input  logic [3:0]            M_in1,
  input  logic [3:0]            M_in0,
  input  logic                  LD_time,
  input  logic                  LD_alarm,
  input  logic [ASEL_W-1:0]     alarm_sel,
  input  logic [NUM_ALARMS-1:0] AL_ON,
  input  logic                  STOP,
  input  logic                  SNOOZE,
  output logic [1:0]            H_out1,
  output logic [3:0]            H_out0,
  output logic [3:0]            M_out1,
  output logic [3:0]            M_out0,
  output logic [3:0]            S_out1,
  output logic [3:0]            S_out0,
  output logic [NUM_ALARMS-1:0] alarm_ring,
  output logic                  ringing,
  output logic                  tick,
  output logic                  load_err
);
  localparam int          PW           = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [11:0] SNOOZE_TICKS = 12'(SNOOZE_MIN * 60);
  localparam logic [7:0]  RING_LAST    = 8'(RING_TIMEOUT_S - 1);

  typedef enum logic [1:0] {IDLE, RING, SNOOZED} state_t;

  logic [PW-1:0] presc;
  logic          in_ok, sel_ok, ld_t, ld_a, adv;
  logic [1:0]    h1_n;
  logic [3:0]    h0_n, m1_n, m0_n, s1_n, s0_n;

  logic [1:0]  al_h1 [NUM_ALARMS];
  logic [3:0]  al_h0 [NUM_ALARMS];
  logic [3:0]  al_m1 [NUM_ALARMS];
  logic [3:0]  al_m0 [NUM_ALARMS];
  state_t      st_q  [NUM_ALARMS];
  state_t      st_d  [NUM_ALARMS];
  logic [7:0]  rs_q  [NUM_ALARMS];
  logic [7:0]  rs_d  [NUM_ALARMS];
  logic [11:0] cd_q  [NUM_ALARMS];
  logic [11:0] cd_d  [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] match, ring_d;

  assign tick   = (presc == PW'(CLK_DIV - 1));
  assign in_ok  = (H_in0 <= 4'd9) && (M_in0 <= 4'd9) && (M_in1 <= 4'd5) &&
                  ((H_in1 < 2'd2) || ((H_in1 == 2'd2) && (H_in0 <= 4'd3)));
  assign sel_ok = (32'(alarm_sel) < NUM_ALARMS);
  assign ld_t   = LD_time && in_ok;
  assign ld_a   = LD_alarm && in_ok && sel_ok;
  // A time load wins over a coincident tick, so it can never produce an alarm match.
  assign adv    = tick && !ld_t;

  always_comb begin
    {h1_n, h0_n, m1_n, m0_n, s1_n, s0_n} = {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
    if (tick) begin
      if (S_out0 != 4'd9) s0_n = S_out0 + 4'd1;
      else begin
        s0_n = 4'd0;
        if (S_out1 != 4'd5) s1_n = S_out1 + 4'd1;
        else begin
          s1_n = 4'd0;
          if (M_out0 != 4'd9) m0_n = M_out0 + 4'd1;
          else begin
            m0_n = 4'd0;
            if (M_out1 != 4'd5) m1_n = M_out1 + 4'd1;
            else begin
              m1_n = 4'd0;
              if ((H_out1 == 2'd2) && (H_out0 == 4'd3)) begin
                h1_n = 2'd0;
                h0_n = 4'd0;
              end else if (H_out0 == 4'd9) begin
                h0_n = 4'd0;
                h1_n = H_out1 + 2'd1;
              end else begin
                h0_n = H_out0 + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      match[i] = adv && (s1_n == 4'd0) && (s0_n == 4'd0) && (h1_n == al_h1[i]) &&
                 (h0_n == al_h0[i]) && (m1_n == al_m1[i]) && (m0_n == al_m0[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      st_d[i] = st_q[i];
      rs_d[i] = rs_q[i];
      cd_d[i] = cd_q[i];
      if (!AL_ON[i] || (ld_a && (alarm_sel == ASEL_W'(i)))) begin
        st_d[i] = IDLE;
      end else begin
        case (st_q[i])
          IDLE: begin
            if (match[i]) begin
              st_d[i] = RING;
              rs_d[i] = 8'd0;
            end
          end
          RING: begin
            if (STOP) st_d[i] = IDLE;
            else if (SNOOZE) begin
              st_d[i] = SNOOZED;
              cd_d[i] = SNOOZE_TICKS;
            end else if (tick) begin
              if (rs_q[i] == RING_LAST) st_d[i] = IDLE;
              else rs_d[i] = rs_q[i] + 8'd1;
            end
          end
          SNOOZED: begin
            if (STOP) st_d[i] = IDLE;
            else if (tick) begin
              if (cd_q[i] <= 12'd1) begin
                st_d[i] = RING;
                rs_d[i] = 8'd0;
                cd_d[i] = 12'd0;
              end else begin
                cd_d[i] = cd_q[i] - 12'd1;
              end
            end
          end
          default: st_d[i] = IDLE;
        endcase
      end
      ring_d[i] = (st_d[i] == RING);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc      <= '0;
      H_out1     <= '0;
      H_out0     <= '0;
      M_out1     <= '0;
      M_out0     <= '0;
      S_out1     <= '0;
      S_out0     <= '0;
      load_err   <= 1'b0;
      alarm_ring <= '0;
      ringing    <= 1'b0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        st_q[i]  <= IDLE;
        rs_q[i]  <= '0;
        cd_q[i]  <= '0;
        al_h1[i] <= '0;
        al_h0[i] <= '0;
        al_m1[i] <= '0;
        al_m0[i] <= '0;
      end
    end else begin
      load_err <= (LD_time && !in_ok) || (LD_alarm && !(in_ok && sel_ok));
      if (ld_t) begin
        presc  <= '0;
        H_out1 <= H_in1;
        H_out0 <= H_in0;
        M_out1 <= M_in1;
        M_out0 <= M_in0;
        S_out1 <= 4'd0;
        S_out0 <= 4'd0;
      end else begin
        presc  <= tick ? '0 : presc + 1'b1;
        H_out1 <= h1_n;
        H_out0 <= h0_n;
        M_out1 <= m1_n;
        M_out0 <= m0_n;
        S_out1 <= s1_n;
        S_out0 <= s0_n;
      end
      for (int i = 0; i < NUM_ALARMS; i++) begin
        st_q[i] <= st_d[i];
        rs_q[i] <= rs_d[i];
        cd_q[i] <= cd_d[i];
        if (ld_a && (alarm_sel == ASEL_W'(i))) begin
          al_h1[i] <= H_in1;
          al_h0[i] <= H_in0;
          al_m1[i] <= M_in1;
          al_m0[i] <= M_in0;
        end
      end
      alarm_ring <= ring_d;
      ringing    <= |ring_d;
    end
  end
endmodule

// File: tb/tb_aclk_multi_alarm_core.sv
// Bench for aclk_multi_alarm_core: table of load vectors plus hand-written alarm/snooze sequences,
// with a wall-clock reference model feeding an expected-result queue.
module tb_aclk_multi_alarm_core;
  localparam int CLK_DIV = 10;
  localparam int NUM_A   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm;
  logic [1:0] alarm_sel;
  logic [3:0] AL_ON;
  logic       STOP, SNOOZE;

  logic [1:0] H_out1;
  logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;
  logic [3:0] alarm_ring;
  logic       ringing, tick, load_err;

  logic [1:0] d3_H_out1;
  logic [3:0] d3_H_out0, d3_M_out1, d3_M_out0, d3_S_out1, d3_S_out0;
  logic [2:0] d3_alarm_ring;
  logic       d3_ringing, d3_tick, d3_load_err;

  aclk_multi_alarm_core #(.CLK_DIV(CLK_DIV), .NUM_ALARMS(NUM_A), .SNOOZE_MIN(5),
                          .RING_TIMEOUT_S(60), .ASEL_W(2)) dut (
    .clk(clk), .reset(reset), .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .alarm_sel(alarm_sel), .AL_ON(AL_ON),
    .STOP(STOP), .SNOOZE(SNOOZE), .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1),
    .M_out0(M_out0), .S_out1(S_out1), .S_out0(S_out0), .alarm_ring(alarm_ring),
    .ringing(ringing), .tick(tick), .load_err(load_err)
  );

  // Three-channel instance: alarm_sel = 3 is representable but out of range here.
  aclk_multi_alarm_core #(.CLK_DIV(CLK_DIV), .NUM_ALARMS(3), .SNOOZE_MIN(5),
                          .RING_TIMEOUT_S(60), .ASEL_W(2)) dut3 (
    .clk(clk), .reset(reset), .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .alarm_sel(alarm_sel), .AL_ON(AL_ON[2:0]),
    .STOP(STOP), .SNOOZE(SNOOZE), .H_out1(d3_H_out1), .H_out0(d3_H_out0), .M_out1(d3_M_out1),
    .M_out0(d3_M_out0), .S_out1(d3_S_out1), .S_out0(d3_S_out0), .alarm_ring(d3_alarm_ring),
    .ringing(d3_ringing), .tick(d3_tick), .load_err(d3_load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tick;
    logic       err;
    logic [1:0] h1;
    logic [3:0] h0, m1, m0, s1, s0;
  } obs_t;

  typedef struct {
    bit         ldt;
    bit         lda;
    logic [1:0] sel;
    logic [1:0] h1;
    logic [3:0] h0, m1, m0;
    bit         err;
    bit         err3;
  } lvec_t;

  obs_t  sbq[$];
  obs_t  last_exp;
  lvec_t tbl[10];
  int    checks = 0;
  int    errors = 0;
  int    tm = 0;
  int    pc = 0;
  bit    tick_edge;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit load_ok();
    int hv, mv;
    hv = int'(H_in1) * 10 + int'(H_in0);
    mv = int'(M_in1) * 10 + int'(M_in0);
    return (H_in0 <= 4'd9) && (M_in0 <= 4'd9) && (hv <= 23) && (mv <= 59);
  endfunction

  // Predict the effect of the coming edge, queue it, then compare once the DUT has clocked it.
  task automatic step();
    obs_t e, x;
    bit   ok;
    ok = load_ok();
    tick_edge = 1'b0;
    if (reset) begin
      tm = 0;
      pc = 0;
      e.err = 1'b0;
    end else begin
      e.err = (LD_time && !ok) || (LD_alarm && !(ok && (int'(alarm_sel) < NUM_A)));
      if (LD_time && ok) begin
        tm = (int'(H_in1) * 10 + int'(H_in0)) * 3600 + (int'(M_in1) * 10 + int'(M_in0)) * 60;
        pc = 0;
      end else if (pc == CLK_DIV - 1) begin
        pc = 0;
        tm = (tm + 1) % 86400;
        tick_edge = 1'b1;
      end else begin
        pc++;
      end
    end
    e.tick = (pc == CLK_DIV - 1);
    e.h1   = 2'((tm / 3600) / 10);
    e.h0   = 4'((tm / 3600) % 10);
    e.m1   = 4'(((tm / 60) % 60) / 10);
    e.m0   = 4'((tm / 60) % 10);
    e.s1   = 4'((tm % 60) / 10);
    e.s0   = 4'(tm % 10);
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    x = sbq.pop_front();
    last_exp = x;
    cmp("tick", tick, x.tick);
    cmp("load_err", load_err, x.err);
    cmp("H_out1", H_out1, x.h1);
    cmp("H_out0", H_out0, x.h0);
    cmp("M_out1", M_out1, x.m1);
    cmp("M_out0", M_out0, x.m0);
    cmp("S_out1", S_out1, x.s1);
    cmp("S_out0", S_out0, x.s0);
  endtask

  task automatic run_ticks(input int n);
    int k = 0;
    while (k < n) begin
      step();
      if (tick_edge) k++;
    end
  endtask

  task automatic set_hm(input int a, input int b, input int c, input int d);
    H_in1 = 2'(a);
    H_in0 = 4'(b);
    M_in1 = 4'(c);
    M_in0 = 4'(d);
  endtask

  initial begin
    tbl[0] = '{ldt: 1, lda: 0, sel: 0, h1: 1, h0: 2, m1: 3, m0: 4,  err: 0, err3: 0};
    tbl[1] = '{ldt: 1, lda: 0, sel: 0, h1: 2, h0: 5, m1: 0, m0: 0,  err: 1, err3: 1};
    tbl[2] = '{ldt: 1, lda: 0, sel: 0, h1: 0, h0: 9, m1: 6, m0: 0,  err: 1, err3: 1};
    tbl[3] = '{ldt: 1, lda: 0, sel: 0, h1: 0, h0: 10, m1: 0, m0: 0, err: 1, err3: 1};
    tbl[4] = '{ldt: 1, lda: 0, sel: 0, h1: 3, h0: 0, m1: 0, m0: 0,  err: 1, err3: 1};
    tbl[5] = '{ldt: 0, lda: 1, sel: 1, h1: 0, h0: 7, m1: 4, m0: 5,  err: 0, err3: 0};
    tbl[6] = '{ldt: 1, lda: 1, sel: 3, h1: 2, h0: 3, m1: 5, m0: 9,  err: 0, err3: 1};
    tbl[7] = '{ldt: 0, lda: 1, sel: 2, h1: 2, h0: 4, m1: 0, m0: 0,  err: 1, err3: 1};
    tbl[8] = '{ldt: 0, lda: 1, sel: 0, h1: 0, h0: 8, m1: 5, m0: 10, err: 1, err3: 1};
    tbl[9] = '{ldt: 1, lda: 0, sel: 0, h1: 2, h0: 3, m1: 5, m0: 9,  err: 0, err3: 0};

    reset = 1'b1; LD_time = 1'b0; LD_alarm = 1'b0; alarm_sel = 2'd0;
    AL_ON = 4'b0000; STOP = 1'b0; SNOOZE = 1'b0;
    set_hm(0, 0, 0, 0);
    @(negedge clk);
    step();
    step();
    cmp("rst_ring", alarm_ring, 4'b0000);
    cmp("rst_ringing", ringing, 1'b0);

    reset = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (k == 9 || k == 19) cmp("tick_cycle", tick, 1'b1);
      if (k == 20) cmp("s0_after_20", S_out0, 4'd2);
    end
    cmp("idle_ring", alarm_ring, 4'b0000);

    for (int i = 0; i < 10; i++) begin
      LD_time = tbl[i].ldt;
      LD_alarm = tbl[i].lda;
      alarm_sel = tbl[i].sel;
      set_hm(int'(tbl[i].h1), int'(tbl[i].h0), int'(tbl[i].m1), int'(tbl[i].m0));
      step();
      LD_time = 1'b0;
      LD_alarm = 1'b0;
      cmp("tbl_err", load_err, tbl[i].err);
      cmp("tbl_err3", d3_load_err, tbl[i].err3);
    end
    cmp("d3_time", {d3_H_out1, d3_H_out0, d3_M_out1, d3_M_out0, d3_S_out1, d3_S_out0},
        {last_exp.h1, last_exp.h0, last_exp.m1, last_exp.m0, last_exp.s1, last_exp.s0});
    cmp("d3_tick", d3_tick, last_exp.tick);
    cmp("d3_ring", {d3_ringing, d3_alarm_ring}, 4'b0000);

    run_ticks(60);
    cmp("wrap", {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0}, 0);

    set_hm(0, 7, 3, 0); LD_alarm = 1'b1; alarm_sel = 2'd2; step(); LD_alarm = 1'b0;
    AL_ON = 4'b0100;
    set_hm(0, 7, 2, 9); LD_time = 1'b1; step(); LD_time = 1'b0;
    run_ticks(59);
    cmp("pre_ring", alarm_ring, 4'b0000);
    run_ticks(1);
    cmp("ring_ch2", alarm_ring, 4'b0100);
    cmp("ringing_ch2", ringing, 1'b1);
    run_ticks(59);
    cmp("still_ring", alarm_ring, 4'b0100);
    run_ticks(1);
    cmp("timeout", alarm_ring, 4'b0000);
    cmp("timeout_ringing", ringing, 1'b0);

    AL_ON = 4'b0001;
    set_hm(1, 0, 0, 0); LD_alarm = 1'b1; alarm_sel = 2'd0; step(); LD_alarm = 1'b0;
    set_hm(0, 9, 5, 9); LD_time = 1'b1; step(); LD_time = 1'b0;
    run_ticks(60);
    cmp("ring_ch0", alarm_ring, 4'b0001);
    SNOOZE = 1'b1; step(); SNOOZE = 1'b0;
    cmp("snoozed", alarm_ring, 4'b0000);
    cmp("snoozed_ringing", ringing, 1'b0);
    run_ticks(299);
    cmp("snooze_quiet", alarm_ring, 4'b0000);
    run_ticks(1);
    cmp("rering", alarm_ring, 4'b0001);
    STOP = 1'b1; SNOOZE = 1'b1; step(); STOP = 1'b0; SNOOZE = 1'b0;
    cmp("stop_wins", alarm_ring, 4'b0000);
    run_ticks(310);
    cmp("no_rering", alarm_ring, 4'b0000);
    cmp("no_rering_ringing", ringing, 1'b0);

    AL_ON = 4'b0010;
    set_hm(1, 2, 0, 0); LD_alarm = 1'b1; alarm_sel = 2'd1; step(); LD_alarm = 1'b0;
    LD_time = 1'b1; step(); LD_time = 1'b0;
    cmp("ldtime_noring", alarm_ring, 4'b0000);
    run_ticks(2);
    cmp("ldtime_noring2", alarm_ring, 4'b0000);
    set_hm(1, 1, 5, 9); LD_time = 1'b1; step(); LD_time = 1'b0;
    run_ticks(60);
    cmp("ring_ch1", alarm_ring, 4'b0010);
    AL_ON = 4'b0000; step();
    cmp("alon_off", alarm_ring, 4'b0000);
    cmp("alon_off_ringing", ringing, 1'b0);
    AL_ON = 4'b0010;
    LD_time = 1'b1; step(); LD_time = 1'b0;
    run_ticks(60);
    cmp("ring_ch1b", alarm_ring, 4'b0010);
    SNOOZE = 1'b1; step(); SNOOZE = 1'b0;
    cmp("snooze_ch1", alarm_ring, 4'b0000);
    reset = 1'b1; step(); reset = 1'b0;
    cmp("rst_snz_ring", alarm_ring, 4'b0000);
    cmp("rst_snz_ringing", ringing, 1'b0);
    // Reset cleared ch1's alarm to 00:00, so the next midnight rings it.
    set_hm(2, 3, 5, 9); LD_time = 1'b1; step(); LD_time = 1'b0;
    run_ticks(59);
    cmp("pre_midnight", alarm_ring, 4'b0000);
    run_ticks(1);
    cmp("midnight_ring", alarm_ring, 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
